// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: shared types and constants for the BOOTCTRL register window.
//   boot_state_t : sequencer state, 2-bit codes visible in STATUS[5:4]
//   OFS_*        : register offsets within the 256-byte window
//   CTRL_*_BIT   : bit positions inside CTRL byte 0
//   apply_be     : byte-enable merge used by the RW registers
// Optional feature macro: BOOTCTRL_CYCLE_COUNTER_EN (CYCLES register at 0x14).
package boot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } boot_state_t;

  localparam logic [7:0] OFS_STATUS   = 8'h00;
  localparam logic [7:0] OFS_CTRL     = 8'h04;
  localparam logic [7:0] OFS_DRAMBASE = 8'h08;
  localparam logic [7:0] OFS_ENTRYPC  = 8'h0C;
  localparam logic [7:0] OFS_TOHOST   = 8'h10;
  localparam logic [7:0] OFS_CYCLES   = 8'h14;

  localparam int unsigned CTRL_HOLD_BIT  = 0;
  localparam int unsigned CTRL_START_BIT = 1;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/boot_seq_fsm.sv
// boot_seq_fsm: core release sequencer (state, RELEASE counter, core reset).
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   hold_set_i     : HOLD written to 1 this cycle (forces IDLE)
//   start_i        : START written with post-write HOLD=0 (enter/restart RELEASE)
//   done_i         : core reported completion (only honoured in RUN)
//   state_o        : current state
//   core_rst_n_o   : registered active-low core reset, high only in RUN/DONE
import boot_ctrl_pkg::*;

module boot_seq_fsm #(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hold_set_i,
  input  logic        start_i,
  input  logic        done_i,
  output boot_state_t state_o,
  output logic        core_rst_n_o
);

  localparam logic [15:0] CNT_LOAD = 16'(RST_CYCLES - 1);

  boot_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        core_rst_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hold_set_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      state_d = ST_RELEASE;
      cnt_d   = CNT_LOAD;
    end else begin
      case (state_q)
        ST_RELEASE: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 16'd1;
        end
        ST_RUN:  if (done_i) state_d = ST_DONE;
        default: ;
      endcase
    end
  end

  // core_rst_n is registered from the next state so it tracks state_q exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= (state_d == ST_RUN) || (state_d == ST_DONE);
    end
  end

  assign state_o      = state_q;
  assign core_rst_n_o = core_rst_n_q;

endmodule

// File: rtl/boot_ctrl_regs.sv
// boot_ctrl_regs: regbus responder for the BOOTCTRL window at BASE_ADDR.
//   ACLK, ARESETN          : clock, asynchronous active-low reset
//   WRADDR/BYTEEN/WREN/WDATA : single-cycle byte-enabled write port
//   RDADDR/RDEN/RDATA      : single-cycle read port, RDATA registered (1-cycle latency)
//   core_rst_n             : active-low reset to the CPU core
//   dram_base, entry_pc    : DRAMBASE / ENTRYPC register values
//   tohost_valid/_data     : core tohost write capture
// Optional feature macro: BOOTCTRL_CYCLE_COUNTER_EN adds CYCLES at offset 0x14.
import boot_ctrl_pkg::*;

module boot_ctrl_regs #(
  parameter logic [15:0] BASE_ADDR  = 16'h1000,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  output logic        core_rst_n,
  output logic [31:0] dram_base,
  output logic [31:0] entry_pc,
  input  logic        tohost_valid,
  input  logic [31:0] tohost_data
);

  boot_state_t state;
  logic        hold_q, hold_d;
  logic [31:0] dram_base_q, entry_pc_q, tohost_q, rdata_q;
  logic [31:0] rd_val;
  logic        wr_hit, rd_hit, ctrl_wr, hold_set, start_go;
  logic        running, done, core_active;
  logic [7:0]  wr_ofs, rd_ofs;

  assign wr_hit = WREN && (WRADDR[15:8] == BASE_ADDR[15:8]);
  assign rd_hit = RDEN && (RDADDR[15:8] == BASE_ADDR[15:8]);
  assign wr_ofs = WRADDR[7:0];
  assign rd_ofs = RDADDR[7:0];

  // CTRL bits live in byte 0; START is judged against the post-write HOLD,
  // so a single write of 0x2 both clears HOLD and starts the sequence.
  assign ctrl_wr  = wr_hit && (wr_ofs == OFS_CTRL) && BYTEEN[0];
  assign hold_d   = ctrl_wr ? WDATA[CTRL_HOLD_BIT] : hold_q;
  assign hold_set = ctrl_wr && WDATA[CTRL_HOLD_BIT];
  assign start_go = ctrl_wr && WDATA[CTRL_START_BIT] && !WDATA[CTRL_HOLD_BIT];

  assign done        = (state == ST_DONE);
  assign core_active = (state == ST_RUN) || done;
  // STATUS.running reports that the core is out of reset, which stays true in DONE.
  assign running     = core_active;

  boot_seq_fsm #(
    .RST_CYCLES (RST_CYCLES)
  ) u_seq (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .hold_set_i   (hold_set),
    .start_i      (start_go),
    .done_i       (tohost_valid && tohost_data[0]),
    .state_o      (state),
    .core_rst_n_o (core_rst_n)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      hold_q      <= 1'b1;
      dram_base_q <= '0;
      entry_pc_q  <= '0;
      tohost_q    <= '0;
    end else begin
      hold_q <= hold_d;
      if (wr_hit && (state == ST_IDLE)) begin
        if (wr_ofs == OFS_DRAMBASE) dram_base_q <= apply_be(dram_base_q, WDATA, BYTEEN);
        if (wr_ofs == OFS_ENTRYPC)  entry_pc_q  <= apply_be(entry_pc_q, WDATA, BYTEEN);
      end
      if (start_go)                         tohost_q <= '0;
      else if (tohost_valid && core_active) tohost_q <= tohost_data;
    end
  end

`ifdef BOOTCTRL_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)              cycles_q <= '0;
    else if (start_go)         cycles_q <= '0;
    else if (state == ST_RUN)  cycles_q <= cycles_q + 32'd1;
  end
`endif

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_ofs)
        OFS_STATUS:   rd_val = {26'd0, state, 1'b0, done, running, hold_q};
        OFS_CTRL:     rd_val = {31'd0, hold_q};
        OFS_DRAMBASE: rd_val = dram_base_q;
        OFS_ENTRYPC:  rd_val = entry_pc_q;
        OFS_TOHOST:   rd_val = tohost_q;
`ifdef BOOTCTRL_CYCLE_COUNTER_EN
        OFS_CYCLES:   rd_val = cycles_q;
`endif
        default:      rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)  rdata_q <= '0;
    else if (RDEN) rdata_q <= rd_val;
  end

  assign RDATA     = rdata_q;
  assign dram_base = dram_base_q;
  assign entry_pc  = entry_pc_q;

endmodule

// File: tb/tb_boot_ctrl_regs.sv
// tb_boot_ctrl_regs: directed self-checking bench for boot_ctrl_regs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_boot_ctrl_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;
  logic        core_rst_n;
  logic [31:0] dram_base;
  logic [31:0] entry_pc;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 ACLK = ~ACLK;

  boot_ctrl_regs #(
    .BASE_ADDR  (16'h1000),
    .RST_CYCLES (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .WRADDR       (WRADDR),
    .BYTEEN       (BYTEEN),
    .WREN         (WREN),
    .WDATA        (WDATA),
    .RDADDR       (RDADDR),
    .RDEN         (RDEN),
    .RDATA        (RDATA),
    .core_rst_n   (core_rst_n),
    .dram_base    (dram_base),
    .entry_pc     (entry_pc),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
  );

  // All bus tasks start and end on a falling edge and occupy one cycle.
  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    @(negedge ACLK);
    WREN = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    RDADDR = a; RDEN = 1'b1;
    @(negedge ACLK);
    RDEN = 1'b0;
    d = RDATA;
  endtask

  task automatic wrrd(input logic [15:0] a, input logic [31:0] wd, output logic [31:0] rdv);
    WRADDR = a; BYTEEN = 4'hF; WDATA = wd; WREN = 1'b1;
    RDADDR = a; RDEN = 1'b1;
    @(negedge ACLK);
    WREN = 1'b0; RDEN = 1'b0;
    rdv = RDATA;
  endtask

  task automatic pulse_tohost(input logic [31:0] d);
    tohost_valid = 1'b1; tohost_data = d;
    @(negedge ACLK);
    tohost_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    ARESETN = 1'b0;
    WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
    RDADDR = '0; RDEN = 1'b0; tohost_valid = 1'b0; tohost_data = '0;
    #3;
    total_cnt++;
    if ({core_rst_n, RDATA, dram_base, entry_pc} !== 97'd0)
      $display("FAIL reset_outputs got rst_n=%b rdata=%h dram=%h pc=%h exp all 0",
               core_rst_n, RDATA, dram_base, entry_pc);
    else pass_cnt++;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0001) $display("FAIL reset_status got %h exp 00000001", v);
    else pass_cnt++;
    total_cnt++;
    if (core_rst_n !== 1'b0) $display("FAIL reset_core_rst_n got %b exp 0", core_rst_n);
    else pass_cnt++;
  endtask

  task automatic test_boot_release;
    logic [31:0] v;
    int unsigned n;
    wr(16'h1008, 4'hF, 32'h2000_0000);
    wr(16'h100C, 4'hF, 32'h0);
    wr(16'h1004, 4'h1, 32'h2);
    n = 0;
    while (core_rst_n !== 1'b1 && n < 100) begin
      n++;
      @(negedge ACLK);
    end
    total_cnt++;
    if (n !== 16) $display("FAIL release_len got %0d exp 16", n);
    else pass_cnt++;
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0022) $display("FAIL run_status got %h exp 00000022", v);
    else pass_cnt++;
    total_cnt++;
    if (dram_base !== 32'h2000_0000) $display("FAIL dram_base_idle got %h exp 20000000", dram_base);
    else pass_cnt++;
  endtask

  task automatic test_run_tohost;
    logic [31:0] v;
    wr(16'h1008, 4'hF, 32'h1234_5678);
    total_cnt++;
    if (dram_base !== 32'h2000_0000) $display("FAIL dram_base_locked got %h exp 20000000", dram_base);
    else pass_cnt++;
    pulse_tohost(32'h2);
    rd(16'h1010, v);
    total_cnt++;
    if (v !== 32'h2) $display("FAIL tohost_run got %h exp 00000002", v);
    else pass_cnt++;
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0022) $display("FAIL still_run got %h exp 00000022", v);
    else pass_cnt++;
    pulse_tohost(32'h1);
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0036) $display("FAIL done_status got %h exp 00000036", v);
    else pass_cnt++;
    rd(16'h1010, v);
    total_cnt++;
    if (v !== 32'h1) $display("FAIL tohost_done got %h exp 00000001", v);
    else pass_cnt++;
    pulse_tohost(32'h4);
    rd(16'h1010, v);
    total_cnt++;
    if (v !== 32'h4) $display("FAIL tohost_in_done got %h exp 00000004", v);
    else pass_cnt++;
    total_cnt++;
    if (core_rst_n !== 1'b1) $display("FAIL core_running_done got %b exp 1", core_rst_n);
    else pass_cnt++;
  endtask

  task automatic test_cycle_counter;
    logic [31:0] v, v2;
    int unsigned n;
    wr(16'h1004, 4'h1, 32'h2);
    total_cnt++;
    if (core_rst_n !== 1'b0) $display("FAIL restart_rst_n got %b exp 0", core_rst_n);
    else pass_cnt++;
    rd(16'h1010, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL restart_tohost_clr got %h exp 00000000", v);
    else pass_cnt++;
    n = 0;
    while (core_rst_n !== 1'b1 && n < 100) begin
      n++;
      @(negedge ACLK);
    end
    total_cnt++;
    if (core_rst_n !== 1'b1) $display("FAIL restart_timeout got rst_n=%b exp 1", core_rst_n);
    else pass_cnt++;
    repeat (99) @(negedge ACLK);
    pulse_tohost(32'h1);
    rd(16'h1014, v);
    repeat (10) @(negedge ACLK);
    rd(16'h1014, v2);
`ifdef BOOTCTRL_CYCLE_COUNTER_EN
    total_cnt++;
    if (v < 32'd99 || v > 32'd101) $display("FAIL cycles_value got %0d exp 100+-1", v);
    else pass_cnt++;
    total_cnt++;
    if (v2 !== v) $display("FAIL cycles_frozen got %0d exp %0d", v2, v);
    else pass_cnt++;
`else
    total_cnt++;
    if (v !== 32'h0) $display("FAIL cycles_unmapped got %h exp 00000000", v);
    else pass_cnt++;
    total_cnt++;
    if (v2 !== 32'h0) $display("FAIL cycles_unmapped2 got %h exp 00000000", v2);
    else pass_cnt++;
`endif
  endtask

  task automatic test_hold_override;
    logic [31:0] v;
    wr(16'h1004, 4'h1, 32'h1);
    total_cnt++;
    if (core_rst_n !== 1'b0) $display("FAIL hold_from_done_rst_n got %b exp 0", core_rst_n);
    else pass_cnt++;
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0001) $display("FAIL hold_from_done got %h exp 00000001", v);
    else pass_cnt++;
    wr(16'h1004, 4'h1, 32'h3);
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0001) $display("FAIL start_with_hold got %h exp 00000001", v);
    else pass_cnt++;
    wr(16'h1004, 4'h1, 32'h2);
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0010) $display("FAIL release_status got %h exp 00000010", v);
    else pass_cnt++;
    wr(16'h1004, 4'h1, 32'h1);
    rd(16'h1000, v);
    total_cnt++;
    if (v !== 32'h0000_0001 || core_rst_n !== 1'b0)
      $display("FAIL hold_in_release got %h rst_n=%b exp 00000001 rst_n=0", v, core_rst_n);
    else pass_cnt++;
  endtask

  task automatic test_regfile;
    logic [31:0] v;
    wr(16'h1008, 4'hF, 32'h0);
    wr(16'h1008, 4'h5, 32'hAABB_CCDD);
    rd(16'h1008, v);
    total_cnt++;
    if (v !== 32'h00BB_00DD) $display("FAIL byteen_merge got %h exp 00BB00DD", v);
    else pass_cnt++;
    rd(16'h1020, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL unmapped_read got %h exp 00000000", v);
    else pass_cnt++;
    wr(16'h2008, 4'hF, 32'hFFFF_FFFF);
    total_cnt++;
    if (dram_base !== 32'h00BB_00DD) $display("FAIL out_of_window_wr got %h exp 00BB00DD", dram_base);
    else pass_cnt++;
    rd(16'h1008, v);
    rd(16'h2008, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL out_of_window_rd got %h exp 00000000", v);
    else pass_cnt++;
    wr(16'h100C, 4'hF, 32'h1111_1111);
    wrrd(16'h100C, 32'h2222_2222, v);
    total_cnt++;
    if (v !== 32'h1111_1111) $display("FAIL rd_during_wr got %h exp 11111111", v);
    else pass_cnt++;
    rd(16'h100C, v);
    total_cnt++;
    if (v !== 32'h2222_2222 || entry_pc !== 32'h2222_2222)
      $display("FAIL entrypc_new got %h port=%h exp 22222222", v, entry_pc);
    else pass_cnt++;
    repeat (3) @(negedge ACLK);
    total_cnt++;
    if (RDATA !== 32'h2222_2222) $display("FAIL rdata_hold got %h exp 22222222", RDATA);
    else pass_cnt++;
    rd(16'h1004, v);
    total_cnt++;
    if (v !== 32'h0000_0001) $display("FAIL ctrl_read got %h exp 00000001", v);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_boot_release();
    test_run_tohost();
    test_cycle_counter();
    test_hold_override();
    test_regfile();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
